// File: rtl/open_log_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : open_log_ctrl
// Description : Nine-entry circular log of 17-bit opening records held in an
//               external one-hot addressed memory, with an oldest-first
//               valid/ready readout stream.
// Revision    : 1.0 - initial release
// ============================================================================
module open_log_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        log_valid,
    input  logic [16:0] log_data,
    output logic        log_ready,
    input  logic        log_clear,
    input  logic        dump_start,
    output logic        dump_valid,
    output logic [16:0] dump_data,
    output logic        dump_last,
    input  logic        dump_ready,
    output logic [3:0]  count,
    output logic [8:0]  mem_idx,
    output logic        mem_wr,
    output logic        mem_enable,
    output logic [16:0] mem_wdata,
    input  logic [16:0] mem_rdata
);

    localparam logic [3:0] c_MAX_COUNT  = 4'd9;
    localparam logic [8:0] c_FIRST_SLOT = 9'b000000001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_OUT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [8:0]  r_wr_ptr;
    logic [8:0]  r_rd_ptr;
    logic [3:0]  r_count;
    logic [3:0]  r_remaining;
    logic        r_pending;
    logic        r_dump_valid;
    logic        r_dump_last;
    logic [16:0] r_dump_data;
    logic [8:0]  r_mem_idx;
    logic        r_mem_wr;
    logic        r_mem_enable;
    logic [16:0] r_mem_wdata;

    logic        w_log_ready;
    logic        w_accept;
    logic [8:0]  w_rd_start;
    logic [8:0]  w_rd_next;
    logic [3:0]  w_remaining_dec;

    // Once the log has wrapped, the slot about to be overwritten is the oldest.
    assign w_rd_start      = (r_count == c_MAX_COUNT) ? r_wr_ptr : c_FIRST_SLOT;
    assign w_rd_next       = {r_rd_ptr[7:0], r_rd_ptr[8]};
    assign w_remaining_dec = r_remaining - 4'd1;
    assign w_log_ready     = (r_state == ST_IDLE) && !r_pending;
    assign w_accept        = w_log_ready && log_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= c_FIRST_SLOT;
            r_rd_ptr     <= c_FIRST_SLOT;
            r_count      <= 4'd0;
            r_remaining  <= 4'd0;
            r_pending    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
            r_dump_data  <= 17'd0;
            r_mem_idx    <= c_FIRST_SLOT;
            r_mem_wr     <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_wdata  <= 17'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (log_clear) begin
                        r_count   <= 4'd0;
                        r_wr_ptr  <= c_FIRST_SLOT;
                        r_pending <= 1'b0;
                    end else if (w_accept) begin
                        r_mem_wdata  <= log_data;
                        r_mem_idx    <= r_wr_ptr;
                        r_mem_enable <= 1'b1;
                        r_mem_wr     <= 1'b1;
                        r_state      <= ST_WRITE;
                        if (dump_start) begin
                            r_pending <= 1'b1;
                        end
                    end else if (r_pending) begin
                        r_pending <= 1'b0;
                        if (r_count != 4'd0) begin
                            r_rd_ptr     <= w_rd_start;
                            r_remaining  <= r_count;
                            r_mem_idx    <= w_rd_start;
                            r_mem_enable <= 1'b1;
                            r_mem_wr     <= 1'b0;
                            r_state      <= ST_RD_ADDR;
                        end
                    end else if (dump_start) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_mem_enable <= 1'b0;
                    r_mem_wr     <= 1'b0;
                    r_wr_ptr     <= {r_wr_ptr[7:0], r_wr_ptr[8]};
                    if (r_count != c_MAX_COUNT) begin
                        r_count <= r_count + 4'd1;
                    end
                    if (dump_start) begin
                        r_pending <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    r_mem_enable <= 1'b0;
                    r_state      <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_dump_data  <= mem_rdata;
                    r_dump_valid <= 1'b1;
                    r_dump_last  <= (r_remaining == 4'd1);
                    r_state      <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        r_rd_ptr     <= w_rd_next;
                        r_remaining  <= w_remaining_dec;
                        if (w_remaining_dec == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_mem_idx    <= w_rd_next;
                            r_mem_enable <= 1'b1;
                            r_mem_wr     <= 1'b0;
                            r_state      <= ST_RD_ADDR;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign log_ready  = w_log_ready;
    assign dump_valid = r_dump_valid;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_last;
    assign count      = r_count;
    assign mem_idx    = r_mem_idx;
    assign mem_wr     = r_mem_wr;
    assign mem_enable = r_mem_enable;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire
